// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit (MULT, MULTU, DIV, DIVU).
// A single shared upper/lower register pair holds the accumulator and
// multiplier while multiplying, and the remainder and dividend/quotient
// while dividing. The unit takes 32 CALC cycles per operation, then
// pulses done for one cycle with the signed-corrected HI/LO result.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI_out,
    output logic [31:0] LO_out
);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  count_reg;
    logic        is_div_reg;
    logic        sign_a_reg;     // already qualified by the signed-op flag
    logic        sign_b_reg;
    logic        b_zero_reg;
    logic [31:0] a_raw_reg;      // divide-by-zero returns the dividend as given
    logic [31:0] operand_reg;    // multiplicand magnitude or divisor magnitude
    logic [31:0] upper_reg;      // product high / partial remainder
    logic [31:0] lower_reg;      // multiplier-then-product-low / dividend-then-quotient

    logic        accept;
    logic        last_iter;
    logic        in_signed;
    logic [31:0] a_mag, b_mag;

    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic [31:0] upper_next, lower_next;
    logic [63:0] product;
    logic [31:0] quot_mag, rem_mag;
    logic [31:0] hi_final, lo_final;

    // MULT and DIV (op[0]==0) are the signed forms.
    assign in_signed = ~op[0];
    assign a_mag     = (in_signed && A[31]) ? (32'd0 - A) : A;
    assign b_mag     = (in_signed && B[31]) ? (32'd0 - B) : B;
    assign accept    = start && (state_reg != CALC);
    assign last_iter = (state_reg == CALC) && (count_reg == 5'd31);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic; start during CALC is simply not looked at
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (count_reg == 5'd31) state_next = DONE;
            DONE:    state_next = start ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Status outputs decoded from the state register
    always_comb begin
        busy = (state_reg == CALC);
        done = (state_reg == DONE);
    end

    // One iteration of shift-add multiply or restoring divide
    always_comb begin
        mul_sum    = {1'b0, upper_reg} + (lower_reg[0] ? {1'b0, operand_reg} : 33'd0);
        div_shift  = {upper_reg, lower_reg[31]};
        div_diff   = div_shift - {1'b0, operand_reg};
        upper_next = mul_sum[32:1];
        lower_next = {mul_sum[0], lower_reg[31:1]};
        if (is_div_reg) begin
            if (div_shift >= {1'b0, operand_reg}) begin
                upper_next = div_diff[31:0];
                lower_next = {lower_reg[30:0], 1'b1};
            end else begin
                upper_next = div_shift[31:0];
                lower_next = {lower_reg[30:0], 1'b0};
            end
        end
    end

    // Sign correction applied to the result of the final iteration
    always_comb begin
        product  = {upper_next, lower_next};
        quot_mag = lower_next;
        rem_mag  = upper_next;
        if (is_div_reg) begin
            if (b_zero_reg) begin
                hi_final = a_raw_reg;
                lo_final = 32'hFFFF_FFFF;
            end else begin
                hi_final = sign_a_reg ? (32'd0 - rem_mag) : rem_mag;
                lo_final = (sign_a_reg ^ sign_b_reg) ? (32'd0 - quot_mag) : quot_mag;
            end
        end else begin
            if (sign_a_reg ^ sign_b_reg) product = 64'd0 - product;
            hi_final = product[63:32];
            lo_final = product[31:0];
        end
    end

    // Operand latch, iteration datapath and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg   <= 5'd0;
            is_div_reg  <= 1'b0;
            sign_a_reg  <= 1'b0;
            sign_b_reg  <= 1'b0;
            b_zero_reg  <= 1'b0;
            a_raw_reg   <= 32'd0;
            operand_reg <= 32'd0;
            upper_reg   <= 32'd0;
            lower_reg   <= 32'd0;
            HI_out      <= 32'd0;
            LO_out      <= 32'd0;
        end else if (accept) begin
            count_reg   <= 5'd0;
            is_div_reg  <= op[1];
            sign_a_reg  <= in_signed & A[31];
            sign_b_reg  <= in_signed & B[31];
            b_zero_reg  <= (B == 32'd0);
            a_raw_reg   <= A;
            operand_reg <= op[1] ? b_mag : a_mag;
            upper_reg   <= 32'd0;
            lower_reg   <= op[1] ? a_mag : b_mag;
        end else if (state_reg == CALC) begin
            count_reg <= count_reg + 5'd1;
            upper_reg <= upper_next;
            lower_reg <= lower_next;
            if (last_iter) begin
                HI_out <= hi_final;
                LO_out <= lo_final;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy, done;
    logic [31:0] HI_out, LO_out;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    mul_div_unit dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .done(done), .HI_out(HI_out), .LO_out(LO_out)
    );

    always #5 clk = ~clk;

    // Wait up to 40 edges for done; returns edges elapsed (-1 on timeout),
    // number of busy samples seen beforehand and the result on the done cycle.
    task automatic wait_done(output int lat, output int busy_cnt,
                             output logic [31:0] hi, output logic [31:0] lo);
        lat = -1; busy_cnt = 0; hi = 32'd0; lo = 32'd0;
        for (int i = 1; i <= 40; i++) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            if (done) begin
                lat = i; hi = HI_out; lo = LO_out;
                break;
            end
        end
    endtask

    // Present an operation for one edge, then scramble the inputs.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; A = 32'h5A5A_A5A5; B = 32'h0F0F_F0F0;
    endtask

    task automatic run_vector(input string name, input logic [1:0] o,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat, bc;
        logic [31:0] hi, lo;
        issue(o, a, b);
        wait_done(lat, bc, hi, lo);
        checks++;
        if (lat !== 32) begin
            errors++; $display("FAIL %s latency got %0d want 32", name, lat);
        end
        checks++;
        if (hi !== exp_hi || lo !== exp_lo) begin
            errors++; $display("FAIL %s result got HI=%h LO=%h want HI=%h LO=%h", name, hi, lo, exp_hi, exp_lo);
        end
        $display("op %s A=%h B=%h -> HI=%h LO=%h lat=%0d", name, a, b, hi, lo, lat);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(negedge clk); rst = 1'b1; start = 1'b1; op = OP_MULTU; A = 32'd3; B = 32'd4;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; start = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || HI_out !== 32'd0 || LO_out !== 32'd0) begin
            errors++; $display("FAIL reset_state got busy=%b done=%b HI=%h LO=%h want 0 0 0 0", busy, done, HI_out, LO_out);
        end
        $display("reset: busy=%b done=%b HI=%h LO=%h", busy, done, HI_out, LO_out);
    endtask

    task automatic test_multu_timing();
        int lat, bc;
        logic [31:0] hi, lo;
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, bc, hi, lo);
        checks++;
        if (lat !== 32) begin errors++; $display("FAIL multu_latency got %0d want 32", lat); end
        checks++;
        if (bc !== 32) begin errors++; $display("FAIL multu_busy_cycles got %0d want 32", bc); end
        checks++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            errors++; $display("FAIL multu_result got HI=%h LO=%h want HI=fffffffe LO=00000001", hi, lo);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL multu_done_pulse got done=%b busy=%b want 0 0", done, busy);
        end
        checks++;
        if (HI_out !== 32'hFFFF_FFFE || LO_out !== 32'h0000_0001) begin
            errors++; $display("FAIL multu_hold got HI=%h LO=%h want fffffffe 00000001", HI_out, LO_out);
        end
        $display("op MULTU ffffffff*ffffffff -> HI=%h LO=%h lat=%0d busy=%0d", hi, lo, lat, bc);
    endtask

    task automatic test_mult();
        run_vector("MULT_neg3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_vector("MULT_min_sq", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    endtask

    task automatic test_div();
        run_vector("DIV_neg7d2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_vector("DIVU_100d7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        run_vector("DIV_min_dm1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run_vector("DIV_7dneg2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    endtask

    task automatic test_div_zero();
        run_vector("DIVU_by0", OP_DIVU, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF);
        run_vector("DIV_neg_by0", OP_DIV, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00, 32'hFFFF_FFFF);
    endtask

    task automatic test_ignore_start();
        int lat, bc;
        logic [31:0] hi, lo;
        issue(OP_MULTU, 32'd3, 32'd5);
        repeat (5) @(posedge clk);
        @(negedge clk); op = OP_DIVU; A = 32'd1000; B = 32'd10; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL ignore_busy got %b want 1", busy); end
        wait_done(lat, bc, hi, lo);
        checks++;
        if (lat !== 26) begin errors++; $display("FAIL ignore_latency got %0d want 26", lat); end
        checks++;
        if (hi !== 32'd0 || lo !== 32'd15) begin
            errors++; $display("FAIL ignore_result got HI=%h LO=%h want 0 f", hi, lo);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL ignore_no_queue got busy=%b done=%b want 0 0", busy, done);
        end
        $display("ignored start: HI=%h LO=%h", hi, lo);
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic [31:0] hi, lo;
        issue(OP_MULTU, 32'd6, 32'd7);
        wait_done(lat, bc, hi, lo);
        checks++;
        if (lat !== 32 || lo !== 32'd42 || hi !== 32'd0) begin
            errors++; $display("FAIL b2b_first got lat=%0d HI=%h LO=%h want 32 0 2a", lat, hi, lo);
        end
        op = OP_DIVU; A = 32'd100; B = 32'd7; start = 1'b1;
        @(posedge clk); #1; start = 1'b0; A = 32'd0; B = 32'd0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || HI_out !== 32'd0 || LO_out !== 32'd42) begin
            errors++; $display("FAIL b2b_hold got busy=%b done=%b HI=%h LO=%h want 1 0 0 2a", busy, done, HI_out, LO_out);
        end
        wait_done(lat, bc, hi, lo);
        checks++;
        if (lat !== 32) begin errors++; $display("FAIL b2b_latency got %0d want 32", lat); end
        checks++;
        if (hi !== 32'd2 || lo !== 32'd14) begin
            errors++; $display("FAIL b2b_second got HI=%h LO=%h want 2 e", hi, lo);
        end
        $display("back-to-back: second HI=%h LO=%h lat=%0d", hi, lo, lat);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        issue(OP_MULTU, 32'd9, 32'd9);
        repeat (10) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || HI_out !== 32'd0 || LO_out !== 32'd0) begin
            errors++; $display("FAIL midreset_state got busy=%b done=%b HI=%h LO=%h want 0 0 0 0", busy, done, HI_out, LO_out);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL midreset_no_done got %0d active cycles want 0", seen); end
        $display("mid-CALC reset: active cycles after reset=%0d", seen);
        run_vector("MULTU_after_rst", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0);
    endtask

    initial begin
        test_reset();
        test_multu_timing();
        test_mult();
        test_div();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative 32-bit multiply/divide unit for the MIPS pipeline. It executes MULT, MULTU, DIV and DIVU and produces the 64-bit HI/LO result that the writeback stage loads into the HI/LO register pair. HI_out drives writeback's HI input, and LO_out drives the data presented with the HI/LO write enable. The unit sits beside the EX stage; the hazard logic stalls the pipeline on `busy`.

## Interface
- No parameters; the datapath is fixed at 32 bits.
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new operation; accepted only when not busy
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- A  input  32  rs operand (multiplicand / dividend)
- B  input  32  rt operand (multiplier / divisor)
- busy  output  1  operation in progress; the pipeline must stall HI/LO consumers
- done  output  1  one-cycle pulse; HI_out/LO_out are valid and writeback asserts its HI/LO write enable
- HI_out  output  32  product[63:32] or remainder
- LO_out  output  32  product[31:0] or quotient

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE: wait for `start`.
  - CALC: exactly 32 iterations, counted by a 5-bit counter from 0 to 31.
  - DONE: one cycle.
- Transitions:
  - IDLE & start -> CALC.
  - CALC & count==31 -> DONE.
  - DONE & start -> CALC (back-to-back operation).
  - DONE & !start -> IDLE.
- Acceptance: `start` is accepted in IDLE or DONE. `start` during CALC is ignored and does not queue.
- At acceptance the unit latches `op`, the sign flags and the operand magnitudes. Later changes on A/B/op have no effect.
- Signed ops (MULT, DIV) compute on |A| and |B|.
- MULT: the 64-bit product is negated when sign(A)^sign(B).
- Multiply: radix-2 shift-add over a 64-bit accumulator, one multiplier bit per CALC cycle.
- Divide: restoring division, one quotient bit per CALC cycle.
- DIV result signs:
  - Quotient is negated when sign(A)^sign(B).
  - Remainder takes the sign of A.
- DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This is the natural magnitude-path result and needs no special handling.
- Divide by zero (DIV or DIVU): HI_out=A as latched, LO_out=0xFFFFFFFF. The unit still takes the full 32 CALC cycles.
- HI_out/LO_out are registered and update only on the CALC->DONE transition. They hold their value until the next completion.

## Timing
- Reset values: state=IDLE, busy=0, done=0, HI_out=0, LO_out=0, counter=0.
- Latency:
  - `start` sampled high at edge T -> busy=1 for the cycles after edges T..T+31 (32 cycles).
  - At edge T+32: done=1 and results are valid for exactly one cycle.
  - Without a new start, done=0 after edge T+33.
- `busy` = (state==CALC). It is combinational from the state register.
- `done` = (state==DONE). It is never high for two consecutive cycles unless a back-to-back start completes, which happens no earlier than 33 cycles later.
- Back-to-back: `start` during the DONE cycle begins the next operation at that edge. The current results stay on HI_out/LO_out until the next DONE.
- Reset mid-CALC: on the next edge the unit returns to IDLE, clears all outputs and drops the operation. No done pulse is produced.
- `rst` and `start` in the same cycle: reset wins and the start is dropped.

## Test plan
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> done exactly 32 cycles after the start edge with HI=0xFFFFFFFE, LO=0x00000001; busy high for exactly 32 cycles.
- MULT A=0xFFFFFFFD (-3), B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT A=0x80000000, B=0x80000000 -> HI=0x40000000, LO=0.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=100, B=7 -> LO=14, HI=2. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU A=0x1234, B=0 -> HI=0x1234, LO=0xFFFFFFFF; latency unchanged.
- start pulsed during CALC with different operands -> ignored, first result intact. start held during DONE -> second operation begins; first result holds until the second done.
- rst asserted at CALC iteration 10 -> next cycle busy=0, done=0, HI/LO=0; no done pulse follows. A fresh start then completes normally.
